pipelined_sparse_tree_adder: RTL and testbench

Parametrised, pipelined successor of the 4-sparse tree adder. It generalises the sparsity and the width, and adds add/subtract mode plus a configurable number of register stages. Transactions move through a valid/ready pipeline with per-stage backpressure. The block is the ALU adder slice for multi-cycle datapaths that need a registered adder with flow control.

---
 rtl/pipelined_sparse_tree_adder_if.sv | 35 +++
 rtl/pipelined_sparse_tree_adder.sv | 175 +++++++++++++++++
 tb/tb_pipelined_sparse_tree_adder.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_sparse_tree_adder_if.sv
// rtl/pipelined_sparse_tree_adder_if.sv - valid/ready operand and result bundle; SPARSE_ADDER_SATURATE_EN adds saturate
interface pipelined_sparse_tree_adder_if #(
    parameter int N_BIT = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [N_BIT-1:0] operand_1;
    logic [N_BIT-1:0] operand_2;
    logic             carry_in;
    logic             sub;
`ifdef SPARSE_ADDER_SATURATE_EN
    logic             saturate;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [N_BIT-1:0] sum;
    logic             carry_out;
    logic             overflow;

    modport master (
`ifdef SPARSE_ADDER_SATURATE_EN
        output saturate,
`endif
        output in_valid, operand_1, operand_2, carry_in, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow
    );

    modport slave (
`ifdef SPARSE_ADDER_SATURATE_EN
        input  saturate,
`endif
        input  in_valid, operand_1, operand_2, carry_in, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow
    );
endinterface

// File: rtl/pipelined_sparse_tree_adder.sv
// rtl/pipelined_sparse_tree_adder.sv - pipelined sparse Sklansky adder/subtractor with valid/ready flow; SPARSE_ADDER_SATURATE_EN enables clamping
module pipelined_sparse_tree_adder #(
    parameter int N_BIT       = 32,
    parameter int SPARSITY    = 4,
    parameter int PIPE_STAGES = 2
) (
    input logic                          clk,
    input logic                          rst,
    pipelined_sparse_tree_adder_if.slave bus
);
    localparam int NG      = N_BIT / SPARSITY;
    localparam int LV      = (NG > 1) ? $clog2(NG) : 0;
    localparam int MID     = (PIPE_STAGES > 2) ? PIPE_STAGES - 2 : 0;
    localparam int MID_DIV = (MID > 0) ? MID : 1;
    localparam int NPL     = (PIPE_STAGES > 1) ? PIPE_STAGES - 1 : 1;

    if (!(SPARSITY == 2 || SPARSITY == 4 || SPARSITY == 8) || N_BIT < 8 ||
        (N_BIT % SPARSITY) != 0 || PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_param_check
        $error("pipelined_sparse_tree_adder: illegal N_BIT/SPARSITY/PIPE_STAGES");
    end

    typedef struct packed {
        logic [N_BIT-1:0] a;
        logic [N_BIT-1:0] b;
        logic             c0;
`ifdef SPARSE_ADDER_SATURATE_EN
        logic             sat;
`endif
        logic [NG-1:0]    gg;
        logic [NG-1:0]    gp;
    } pl_t;

    // Prefix levels completed by the time a transaction sits in payload register s.
    function automatic int levels_done(int s);
        if (MID == 0 || s == 0) return 0;
        return s * (LV / MID_DIV) + ((s < (LV % MID_DIV)) ? s : (LV % MID_DIV));
    endfunction

    // Sklansky levels lo..hi-1 over the group generate/propagate pairs.
    function automatic pl_t prefix(pl_t x, int lo, int hi);
        pl_t y;
        y = x;
        for (int k = 0; k < LV; k++) begin
            if (k >= lo && k < hi) begin
                for (int j = 0; j < NG; j++) begin
                    if (((j >> k) & 1) == 1) begin
                        y.gg[j] = y.gg[j] | (y.gp[j] & y.gg[((j >> k) << k) - 1]);
                        y.gp[j] = y.gp[j] & y.gp[((j >> k) << k) - 1];
                    end
                end
            end
        end
        return y;
    endfunction

    // Carry-select groups muxed by the tree carries; returns {overflow, carry_out, sum}.
    function automatic logic [N_BIT+1:0] finish(pl_t x);
        logic [N_BIT-1:0]    s;
        logic [SPARSITY-1:0] s0;
        logic [SPARSITY-1:0] s1;
        logic [NG:0]         cvec;
        logic                co;
        logic                ov;
        cvec = {x.gg, x.c0};
        s    = '0;
        for (int j = 0; j < NG; j++) begin
            s0 = x.a[j*SPARSITY +: SPARSITY] + x.b[j*SPARSITY +: SPARSITY];
            s1 = s0 + {{(SPARSITY-1){1'b0}}, 1'b1};
            s[j*SPARSITY +: SPARSITY] = cvec[j] ? s1 : s0;
        end
        co = x.gg[NG-1];
        ov = co ^ (s[N_BIT-1] ^ x.a[N_BIT-1] ^ x.b[N_BIT-1]);
`ifdef SPARSE_ADDER_SATURATE_EN
        if (x.sat && ov)
            s = x.a[N_BIT-1] ? {1'b1, {(N_BIT-1){1'b0}}} : {1'b0, {(N_BIT-1){1'b1}}};
`endif
        return {ov, co, s};
    endfunction

    pl_t                    front;
    pl_t                    pl_q   [NPL];
    pl_t                    stg_in [NPL];
    logic [N_BIT-1:0]       b_eff;
    logic [N_BIT-1:0]       g_bit;
    logic [N_BIT-1:0]       p_bit;
    logic                   gg_t;
    logic                   gp_t;
    logic                   full;
    logic [PIPE_STAGES-1:0] vld;
    logic [PIPE_STAGES-1:0] rdy;
    logic [PIPE_STAGES-1:0] stg_v;
    logic [N_BIT+1:0]       fin_res;
    logic [N_BIT+1:0]       res_q;

    // Carry-in is folded into bit 0's generate so the tree yields final carries directly.
    always_comb begin
        front    = '0;
        b_eff    = bus.sub ? ~bus.operand_2 : bus.operand_2;
        front.a  = bus.operand_1;
        front.b  = b_eff;
        front.c0 = bus.sub | bus.carry_in;
`ifdef SPARSE_ADDER_SATURATE_EN
        front.sat = bus.saturate;
`endif
        p_bit    = bus.operand_1 ^ b_eff;
        g_bit    = bus.operand_1 & b_eff;
        g_bit[0] = g_bit[0] | (p_bit[0] & front.c0);
        gg_t     = 1'b0;
        gp_t     = 1'b1;
        for (int j = 0; j < NG; j++) begin
            gg_t = 1'b0;
            gp_t = 1'b1;
            for (int i = 0; i < SPARSITY; i++) begin
                gg_t = g_bit[j*SPARSITY+i] | (p_bit[j*SPARSITY+i] & gg_t);
                gp_t = gp_t & p_bit[j*SPARSITY+i];
            end
            front.gg[j] = gg_t;
            front.gp[j] = gp_t;
        end
    end

    always_comb begin
        stg_in[0] = front;
        for (int s = 1; s < PIPE_STAGES - 1; s++)
            stg_in[s] = prefix(pl_q[s-1], levels_done(s-1), levels_done(s));
        if (PIPE_STAGES == 1)
            fin_res = finish(prefix(front, 0, LV));
        else
            fin_res = finish(prefix(pl_q[NPL-1], levels_done(NPL-1), LV));
    end

    // A stage is ready when empty or when everything downstream of it can move.
    always_comb begin
        rdy      = '0;
        stg_v    = '0;
        full     = 1'b1;
        stg_v[0] = bus.in_valid;
        for (int s = 1; s < PIPE_STAGES; s++)
            stg_v[s] = vld[s-1];
        for (int s = 0; s < PIPE_STAGES; s++) begin
            full = 1'b1;
            for (int k = s; k < PIPE_STAGES; k++)
                full = full & vld[k];
            rdy[s] = bus.out_ready | ~full;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld   <= '0;
            res_q <= '0;
            for (int s = 0; s < PIPE_STAGES - 1; s++)
                pl_q[s] <= '0;
        end else begin
            for (int s = 0; s < PIPE_STAGES - 1; s++) begin
                if (rdy[s]) begin
                    vld[s] <= stg_v[s];
                    if (stg_v[s])
                        pl_q[s] <= stg_in[s];
                end
            end
            if (rdy[PIPE_STAGES-1]) begin
                vld[PIPE_STAGES-1] <= stg_v[PIPE_STAGES-1];
                if (stg_v[PIPE_STAGES-1])
                    res_q <= fin_res;
            end
        end
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = vld[PIPE_STAGES-1];
    assign bus.sum       = res_q[N_BIT-1:0];
    assign bus.carry_out = res_q[N_BIT];
    assign bus.overflow  = res_q[N_BIT+1];
endmodule

// File: tb/tb_pipelined_sparse_tree_adder.sv
// tb/tb_pipelined_sparse_tree_adder.sv - scoreboard bench for pipelined_sparse_tree_adder
module tb_pipelined_sparse_tree_adder;
    localparam int N  = 32;
    localparam int S  = 4;
    localparam int PS = 2;

    typedef struct {
        logic [N-1:0] s;
        logic         co;
        logic         ov;
        int           acc;
        bit           chk;
    } exp_t;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic         sb;
        logic         sat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   rand_or = 1'b0;
    exp_t sbq[$];
    logic [N+1:0] prev_out;
    bit   pstall = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_sparse_tree_adder_if #(.N_BIT(N)) bus ();

    pipelined_sparse_tree_adder #(.N_BIT(N), .SPARSITY(S), .PIPE_STAGES(PS)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input vec_t v, input bit chk);
        exp_t         r;
        logic [N:0]   full;
        logic [N-1:0] be;
        be    = v.sb ? ~v.b : v.b;
        full  = {1'b0, v.a} + {1'b0, be} + {{N{1'b0}}, (v.sb ? 1'b1 : v.cin)};
        r.s   = full[N-1:0];
        r.co  = full[N];
        r.ov  = (v.a[N-1] == be[N-1]) && (r.s[N-1] != v.a[N-1]);
        if (v.sat && r.ov)
            r.s = v.a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        r.acc = 0;
        r.chk = chk;
        return r;
    endfunction

    function automatic exp_t lit(input logic [N-1:0] s, input logic co, input logic ov);
        exp_t r;
        r.s = s; r.co = co; r.ov = ov; r.acc = 0; r.chk = 1'b1;
        return r;
    endfunction

    function automatic vec_t mk(input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic cin, input logic sb, input logic sat);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin; v.sb = sb; v.sat = sat;
        return v;
    endfunction

    function automatic logic [N-1:0] rnd();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return {1'b1, {(N-1){1'b0}}};
            3: return {1'b0, {(N-1){1'b1}}};
            default: return $urandom;
        endcase
    endfunction

    task automatic drive(input vec_t v);
        bus.operand_1 = v.a;
        bus.operand_2 = v.b;
        bus.carry_in  = v.cin;
        bus.sub       = v.sb;
`ifdef SPARSE_ADDER_SATURATE_EN
        bus.saturate  = v.sat;
`endif
        bus.in_valid  = 1'b1;
    endtask

    // Starts and ends on a falling edge; expectation is queued at the accepting edge.
    task automatic send(input vec_t v, input exp_t e);
        drive(v);
        for (int n = 0; n < 200; n++) begin
            #4;
            if (bus.in_ready) begin
                e.acc = cyc;
                sbq.push_back(e);
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        bus.in_valid = 1'b0;
        for (int n = 0; n < 400 && sbq.size() != 0; n++) @(negedge clk);
        check("drain_left", sbq.size(), 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rand_or) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                pstall = 1'b0;
            end else begin
                if (pstall) begin
                    check("stall_valid", bus.out_valid, 1);
                    check("stall_hold", {bus.overflow, bus.carry_out, bus.sum}, prev_out);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_result", bus.out_valid, 0);
                    end else begin
                        e = sbq.pop_front();
                        check("sum", bus.sum, e.s);
                        check("carry_out", bus.carry_out, e.co);
                        check("overflow", bus.overflow, e.ov);
                        if (e.chk) check("latency", cyc - e.acc, PS);
                    end
                end
                pstall   = bus.out_valid && !bus.out_ready;
                prev_out = {bus.overflow, bus.carry_out, bus.sum};
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        vec_t v;
        vec_t bp[4];
        int   acc;
        bus.in_valid  = 1'b0;
        bus.operand_1 = '0;
        bus.operand_2 = '0;
        bus.carry_in  = 1'b0;
        bus.sub       = 1'b0;
`ifdef SPARSE_ADDER_SATURATE_EN
        bus.saturate  = 1'b0;
`endif
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #4;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_sum", bus.sum, 0);
        check("rst_carry_out", bus.carry_out, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_in_ready", bus.in_ready, 1);
        @(negedge clk);

        send(mk(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0), lit(32'h00000000, 1'b1, 1'b0));
        send(mk(32'h0000000F, 32'h00000000, 1'b1, 1'b0, 1'b0), lit(32'h00000010, 1'b0, 1'b0));
        send(mk(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0), lit(32'h80000000, 1'b0, 1'b1));
        send(mk(32'h00000005, 32'h00000007, 1'b1, 1'b1, 1'b0), lit(32'hFFFFFFFE, 1'b0, 1'b0));
        send(mk(32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b0), lit(32'h7FFFFFFF, 1'b1, 1'b1));
`ifdef SPARSE_ADDER_SATURATE_EN
        send(mk(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1), lit(32'h7FFFFFFF, 1'b0, 1'b1));
        send(mk(32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b1), lit(32'h80000000, 1'b1, 1'b1));
`endif
        drain();

        for (int i = 0; i < 4; i++) bp[i] = mk($urandom, $urandom, 1'($urandom), 1'($urandom), 1'b0);
        bus.out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            if (acc < 4) drive(bp[acc]); else bus.in_valid = 1'b0;
            #4;
            if (bus.in_valid && bus.in_ready) begin
                sbq.push_back(model(bp[acc], 1'b0));
                acc++;
            end
            @(negedge clk);
        end
        check("bp_accepts", acc, PS);
        check("bp_in_ready", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 50 && acc < 4; c++) begin
            drive(bp[acc]);
            #4;
            if (bus.in_ready) begin
                sbq.push_back(model(bp[acc], 1'b0));
                acc++;
            end
            @(negedge clk);
        end
        drain();

        send(mk(32'h00001234, 32'h00000001, 1'b0, 1'b0, 1'b0), lit(32'h00001235, 1'b0, 1'b0));
        send(mk(32'h00000010, 32'h00000020, 1'b0, 1'b1, 1'b0), lit(32'hFFFFFFF0, 1'b0, 1'b0));
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sbq.delete();
        #4;
        check("post_rst_out_valid", bus.out_valid, 0);
        @(negedge clk);
        send(mk(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 1'b0), lit(32'h00000100, 1'b0, 1'b0));
        drain();

        rand_or = 1'b1;
        for (int i = 0; i < 300; i++) begin
            v = mk(rnd(), rnd(), 1'($urandom), 1'($urandom), 1'b0);
`ifdef SPARSE_ADDER_SATURATE_EN
            v.sat = 1'($urandom);
`endif
            send(v, model(v, 1'b0));
            if ($urandom_range(0, 4) == 0) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
            end
        end
        bus.in_valid = 1'b0;
        rand_or = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
